fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_pc.sv | 40 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage parameters: default widths and FSM state encodings.
package fetch_unit_pkg;

  localparam int INSTR_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF    = 8;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_pc.sv
// Program counter: reset load, redirect, and wrapping increment.
module fetch_pc #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc_en_i,
  input  logic                branch_en_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Redirect wins over increment; the add wraps naturally at PC_WIDTH bits.
  always_comb begin
    pc_d = pc_q;
    if (branch_en_i) begin
      pc_d = branch_target_i;
    end else if (inc_en_i) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/hold FSM feeding the instruction register.
// Optional memory-wait counter enabled by defining FETCH_STALL_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  INSTRUCTION_WIDTH = INSTR_WIDTH_DEF,
  parameter int                  PC_WIDTH          = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         branch_en,
  input  logic [PC_WIDTH-1:0]          branch_target,
  output logic                         mem_rd,
  output logic [PC_WIDTH-1:0]          mem_addr,
  input  logic                         mem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] ir,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [15:0]                  stall_count
);

  fetch_state_e                 state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0]          pc_out_q, pc_out_d;
  logic [PC_WIDTH-1:0]          pc_s;
  logic                         mem_rd_s;
  logic                         xfer_s;
  logic                         load_s;

  fetch_pc #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk             (clk),
    .reset           (reset),
    .inc_en_i        (load_s),
    .branch_en_i     (branch_en),
    .branch_target_i (branch_target),
    .pc_o            (pc_s)
  );

  // A transfer completes only while a request is actually outstanding.
  assign mem_rd_s = (state_q == S_REQ) && !halt;
  assign xfer_s   = mem_rd_s && mem_ack;
  assign load_s   = xfer_s && !branch_en;

  // Next-state and IR/pc_out capture.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    if (branch_en) begin
      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:   state_d = xfer_s ? S_HOLD : S_REQ;
        S_HOLD:  state_d = ir_ready ? S_REQ : S_HOLD;
        default: state_d = S_REQ;
      endcase
    end
    if (load_s) begin
      ir_d     = mem_rdata;
      pc_out_d = pc_s;
    end else begin
      ir_d     = ir_q;
      pc_out_d = pc_out_q;
    end
  end

  // FSM and instruction register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      ir_q     <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign mem_rd   = mem_rd_s;
  assign mem_addr = pc_s;
  assign ir       = ir_q;
  assign ir_valid = (state_q == S_HOLD);
  assign pc_out   = pc_out_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Count request cycles with no acknowledge, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (mem_rd_s && !mem_ack && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based scoreboard on the IR handshake.
module tb_fetch_unit;

  localparam logic [7:0] RST_PC = 8'h10;
  localparam logic [7:0] HI     = 8'hA5;

  logic        clk = 1'b0;
  logic        reset, halt, branch_en, mem_ack, ir_ready;
  logic [7:0]  branch_target;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc_out;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  assign mem_rdata = {HI, mem_addr};

  fetch_unit #(
    .INSTRUCTION_WIDTH (16),
    .PC_WIDTH          (8),
    .RESET_PC          (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .halt          (halt),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .pc_out        (pc_out),
    .stall_count   (stall_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back({HI, a, a});
  endtask

  // Monitor: every consumed instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && ir_valid && ir_ready) begin
      logic [23:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_xfer: got ir=%h pc_out=%h expected none", ir, pc_out);
      end else begin
        e = exp_q.pop_front();
        if ({ir, pc_out} !== e) begin
          n_fail++;
          $display("FAIL xfer: got ir=%h pc_out=%h expected ir=%h pc_out=%h",
                   ir, pc_out, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_stall;
    reset = 1'b1; halt = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    mem_ack = 1'b0; ir_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_pc_out", pc_out, 8'h00);
    chk("rst_addr", mem_addr, RST_PC);
    chk("rst_stall", stall_count, 0);

    // Free-running fetch: one instruction every two cycles.
    reset = 1'b0; mem_ack = 1'b1; #1;
    chk("first_rd", mem_rd, 1);
    for (int k = 0; k < 6; k++) begin
      chk("seq_addr", mem_addr, RST_PC + 8'(k));
      chk("seq_rd", mem_rd, 1);
      chk("seq_valid_lo", ir_valid, 0);
      push(RST_PC + 8'(k));
      tick();
      chk("seq_valid_hi", ir_valid, 1);
      chk("seq_rd_hold", mem_rd, 0);
      tick();
    end

    // Delayed acknowledge, then hold with consumer not ready.
    mem_ack = 1'b0; ir_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_rd", mem_rd, 1);
      chk("wait_addr", mem_addr, 8'h16);
      chk("wait_valid", ir_valid, 0);
      tick();
    end
    mem_ack = 1'b1;
    push(8'h16);
    tick();
    chk("ack_valid", ir_valid, 1);
`ifdef FETCH_STALL_COUNT_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    chk("stall_count", stall_count, exp_stall);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ir", ir, {HI, 8'h16});
      chk("hold_pc_out", pc_out, 8'h16);
      chk("hold_rd", mem_rd, 0);
      chk("hold_valid", ir_valid, 1);
      tick();
    end
    ir_ready = 1'b1;
    tick();

    // Halt blocks requests and ack is ignored; release resumes immediately.
    halt = 1'b1; #1;
    chk("halt_rd", mem_rd, 0);
    tick();
    chk("halt_valid", ir_valid, 0);
    chk("halt_addr", mem_addr, 8'h17);
    halt = 1'b0; #1;
    chk("unhalt_rd", mem_rd, 1);
    push(8'h17);
    tick();
    tick();

    // Branch coincident with ack discards the returned word.
    branch_en = 1'b1; branch_target = 8'h40;
    tick();
    branch_en = 1'b0; #1;
    chk("br_valid", ir_valid, 0);
    chk("br_addr", mem_addr, 8'h40);
    chk("br_ir", ir, {HI, 8'h17});
    chk("br_pc_out", pc_out, 8'h17);
    push(8'h40);
    tick();
    tick();

    // Branch in hold squashes the held instruction.
    ir_ready = 1'b0;
    tick();
    chk("sq_valid_pre", ir_valid, 1);
    branch_en = 1'b1; branch_target = 8'hFE;
    tick();
    branch_en = 1'b0; ir_ready = 1'b1; #1;
    chk("sq_valid", ir_valid, 0);
    chk("sq_addr", mem_addr, 8'hFE);

    // PC wrap from all-ones.
    push(8'hFE);
    tick(); tick();
    chk("wrap_ff", mem_addr, 8'hFF);
    push(8'hFF);
    tick(); tick();
    chk("wrap_00", mem_addr, 8'h00);
    push(8'h00);
    tick(); tick();

    // Reset while a request is pending.
    mem_ack = 1'b0;
    tick(); tick();
    chk("pend_rd", mem_rd, 1);
    reset = 1'b1; mem_ack = 1'b1; ir_ready = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b0; #1;
    chk("mid_rst_addr", mem_addr, RST_PC);
    chk("mid_rst_valid", ir_valid, 0);
    chk("mid_rst_ir", ir, 16'h0000);
    chk("mid_rst_pc_out", pc_out, 8'h00);
    chk("mid_rst_stall", stall_count, 0);
    tick(); tick();

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
